// File: rtl/muldiv_ctrl.sv
// Sequencer between the CPU control unit and the shared multiply/divide datapaths:
// launches one unit, counts its fixed latency, captures the result into HI/LO.
module muldiv_ctrl #(
    parameter int MULT_LAT = 34,
    parameter int DIV_LAT  = 34,
    parameter int CNT_W    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        abort,
    input  logic [31:0] divisor,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic        mult_init,
    output logic        mult_stop,
    output logic        div_init,
    output logic        div_stop,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_ABORT   = 3'd4
    } state_t;

    localparam logic SEL_MULT = 1'b0;
    localparam logic SEL_DIV  = 1'b1;
    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;
    logic              done_q, done_d, dz_q, dz_d, busy_q, busy_d;
    logic              mi_q, mi_d, ms_q, ms_d, di_q, di_d, ds_q, ds_d;

    // Next-state, counter and result-capture logic.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (op == OP_MULT) begin
                        sel_d   = SEL_MULT;
                        state_d = S_LAUNCH;
                    end else if (op == OP_DIV) begin
                        // A zero divisor is reported immediately; the divider never starts.
                        if (divisor != 32'd0) begin
                            sel_d   = SEL_DIV;
                            state_d = S_LAUNCH;
                        end else begin
                            done_d = 1'b1;
                            dz_d   = 1'b1;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else begin
                    cnt_d   = (sel_q == SEL_DIV) ? DIV_LOAD : MULT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_CAPTURE: begin
                // Abort wins over a same-cycle capture.
                if (abort) begin
                    state_d = S_ABORT;
                end else begin
                    hi_d    = (sel_q == SEL_DIV) ? div_hi : mult_hi;
                    lo_d    = (sel_q == SEL_DIV) ? div_lo : mult_lo;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control pulses are decoded from the next state so they come straight out of flops.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        mi_d   = (state_d == S_LAUNCH) && (sel_d == SEL_MULT);
        di_d   = (state_d == S_LAUNCH) && (sel_d == SEL_DIV);
        ms_d   = (state_d == S_ABORT)  && (sel_d == SEL_MULT);
        ds_d   = (state_d == S_ABORT)  && (sel_d == SEL_DIV);
    end

    // State, counter, HI/LO and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sel_q   <= SEL_MULT;
            cnt_q   <= {CNT_W{1'b0}};
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            mi_q    <= 1'b0;
            ms_q    <= 1'b0;
            di_q    <= 1'b0;
            ds_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            mi_q    <= mi_d;
            ms_q    <= ms_d;
            di_q    <= di_d;
            ds_q    <= ds_d;
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign done      = done_q;
    assign div_zero  = dz_q;
    assign busy      = busy_q;
    assign mult_init = mi_q;
    assign mult_stop = ms_q;
    assign div_init  = di_q;
    assign div_stop  = ds_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: expected HI/LO/div_zero queued at issue, checked
// by a monitor on every done pulse; timing and pulse counts checked inline.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic        abort = 1'b0;
    logic [31:0] divisor = 32'd0;
    logic [31:0] mult_hi = 32'd0, mult_lo = 32'd0, div_hi = 32'd0, div_lo = 32'd0;
    logic        mult_init, mult_stop, div_init, div_stop, busy, done, div_zero;
    logic [31:0] hi, lo;

    muldiv_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .abort(abort), .divisor(divisor),
        .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
        .mult_init(mult_init), .mult_stop(mult_stop), .div_init(div_init), .div_stop(div_stop),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    logic [64:0] exp_q[$];
    int sb_pass = 0, sb_total = 0;
    int mi_cnt = 0, ms_cnt = 0, di_cnt = 0, ds_cnt = 0, busy_cnt = 0, done_cnt = 0;
    bit viol = 1'b0;
    int pass_cnt = 0, total_cnt = 0;

    // Monitor: pulse counters, exclusivity, and scoreboard compare on each done.
    always @(negedge clk) begin
        logic [64:0] e;
        if (mult_init) mi_cnt++;
        if (mult_stop) ms_cnt++;
        if (div_init)  di_cnt++;
        if (div_stop)  ds_cnt++;
        if (busy)      busy_cnt++;
        if ((mult_init || mult_stop) && (div_init || div_stop)) viol = 1'b1;
        if ((mult_init && mult_stop) || (div_init && div_stop)) viol = 1'b1;
        if (done) begin
            done_cnt++;
            sb_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_done got hi=%h lo=%h dz=%b required no done", hi, lo, div_zero);
            end else begin
                e = exp_q.pop_front();
                if ({hi, lo, div_zero} === e) sb_pass++;
                else $display("FAIL sb_result got hi=%h lo=%h dz=%b required hi=%h lo=%h dz=%b",
                              hi, lo, div_zero, e[64:33], e[32:1], e[0]);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s got %0h required %0h", nm, act, req);
    endtask

    // Drive one request; returns at the negedge right after the acceptance edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] dv, input int unit, input string nm);
        @(posedge clk); #1;
        start = 1'b1; op = o; divisor = dv;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk({nm, "_mult_init_E+1"}, {63'd0, mult_init}, (unit == 0) ? 64'd1 : 64'd0);
        chk({nm, "_div_init_E+1"},  {63'd0, div_init},  (unit == 1) ? 64'd1 : 64'd0);
    endtask

    // Count edges after acceptance until done is seen; bounded.
    task automatic wait_done(input string nm, input int req_n);
        int n;
        n = 0;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk); @(negedge clk);
            if (done) begin n = i; break; end
        end
        chk({nm, "_done_latency"}, 64'(n), 64'(req_n));
    endtask

    initial begin
        int b_mi, b_di, b_ms, b_busy, b_done;
        // Reset and idle
        #2;
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_outs", {57'd0, busy, done, div_zero, mult_init, mult_stop, div_init, div_stop}, 64'd0);
        #20 rst = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("idle_counts", 64'(mi_cnt + di_cnt + ms_cnt + ds_cnt + busy_cnt + done_cnt), 64'd0);
        chk("idle_hilo", {hi, lo}, 64'd0);

        // MULT
        mult_hi = 32'h0000_0001; mult_lo = 32'h0000_0002;
        b_mi = mi_cnt; b_di = di_cnt; b_busy = busy_cnt;
        exp_q.push_back({32'h1, 32'h2, 1'b0});
        issue(2'b00, 32'd0, 0, "mult");
        chk("mult_busy_E+1", {63'd0, busy}, 64'd1);
        wait_done("mult", 36);
        @(posedge clk); #1;
        chk("mult_init_count", 64'(mi_cnt - b_mi), 64'd1);
        chk("mult_no_div_init", 64'(di_cnt - b_di), 64'd0);
        chk("mult_busy_cycles", 64'(busy_cnt - b_busy), 64'd36);

        // DIV
        div_hi = 32'h3; div_lo = 32'h5;
        b_mi = mi_cnt; b_di = di_cnt;
        exp_q.push_back({32'h3, 32'h5, 1'b0});
        issue(2'b01, 32'd7, 1, "div");
        wait_done("div", 36);
        @(posedge clk); #1;
        chk("div_init_count", 64'(di_cnt - b_di), 64'd1);
        chk("div_no_mult_init", 64'(mi_cnt - b_mi), 64'd0);

        // Preload HI/LO with a MULT, then divide by zero
        mult_hi = 32'h0000_AAAA; mult_lo = 32'h0000_5555;
        exp_q.push_back({32'hAAAA, 32'h5555, 1'b0});
        issue(2'b00, 32'd0, 0, "preload");
        wait_done("preload", 36);
        @(posedge clk); #1;
        b_di = di_cnt; b_busy = busy_cnt;
        exp_q.push_back({32'hAAAA, 32'h5555, 1'b1});
        issue(2'b01, 32'd0, 2, "dz");
        chk("dz_done_E+1", {62'd0, done, div_zero}, 64'd3);
        @(negedge clk);
        chk("dz_pulse_one_cycle", {62'd0, done, div_zero}, 64'd0);
        chk("dz_no_div_init", 64'(di_cnt - b_di), 64'd0);
        chk("dz_no_busy", 64'(busy_cnt - b_busy), 64'd0);

        // Illegal op ignored
        b_mi = mi_cnt; b_di = di_cnt; b_busy = busy_cnt;
        issue(2'b10, 32'd5, 2, "illegal");
        repeat (3) @(negedge clk);
        chk("illegal_ignored", 64'(mi_cnt - b_mi + di_cnt - b_di + busy_cnt - b_busy), 64'd0);

        // Abort in WAIT, with an ignored second start
        mult_hi = 32'h1234; mult_lo = 32'h5678;
        b_mi = mi_cnt; b_ms = ms_cnt; b_done = done_cnt;
        issue(2'b00, 32'd0, 0, "abort");
        repeat (5) @(posedge clk);
        #1 start = 1'b1; op = 2'b00;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_stop_high", {62'd0, mult_stop, div_stop}, 64'd2);
        @(negedge clk);
        chk("abort_idle", {61'd0, busy, mult_stop, div_stop}, 64'd0);
        repeat (40) @(posedge clk); #1;
        chk("abort_init_count", 64'(mi_cnt - b_mi), 64'd1);
        chk("abort_stop_count", 64'(ms_cnt - b_ms), 64'd1);
        chk("abort_no_done", 64'(done_cnt - b_done), 64'd0);
        chk("abort_hilo_kept", {hi, lo}, {32'hAAAA, 32'h5555});

        // Async reset mid-WAIT
        b_ms = ms_cnt; b_done = done_cnt;
        issue(2'b00, 32'd0, 0, "arst");
        repeat (21) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        #2 rst = 1'b1;
        repeat (40) @(posedge clk); #1;
        chk("arst_no_stop_done", 64'(ms_cnt - b_ms + done_cnt - b_done), 64'd0);
        mult_hi = 32'h1; mult_lo = 32'h2;
        exp_q.push_back({32'h1, 32'h2, 1'b0});
        issue(2'b00, 32'd0, 0, "post_rst");
        wait_done("post_rst", 36);
        repeat (3) @(posedge clk); #1;

        chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("pulse_exclusive", {63'd0, viol}, 64'd0);
        chk("stop_div_never", 64'(ds_cnt), 64'd0);
        pass_cnt += sb_pass;
        total_cnt += sb_total;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencer that sits between the CPU control unit and the shared multiply and divide datapaths. It accepts one MULT/DIV request at a time and fires the selected unit's init/stop pulses. It counts the unit's fixed latency, captures the 64-bit result into the architectural HI/LO registers, and holds busy high so the control unit stalls. Divide-by-zero is detected up front, and the divider is never launched in that case.

Parameters:
MULT_LAT, 34, cycles from the end of the mult init pulse until mult result outputs are valid (load + 32 Booth steps + result write).
DIV_LAT, 34, same for the divider.
CNT_W, 6, width of the latency counter; must hold max(MULT_LAT, DIV_LAT).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  request strobe, sampled only in IDLE.
op  in  2  00 = MULT, 01 = DIV, 10/11 = illegal (request ignored).
abort  in  1  cancel the in-flight operation.
divisor  in  32  divisor operand (b), sampled with start for the zero check.
mult_hi, mult_lo  in  32 each  multiplier result.
div_hi, div_lo  in  32 each  divider result (remainder, quotient).
mult_init, mult_stop  out  1 each  multiplier control pulses.
div_init, div_stop  out  1 each  divider control pulses.
hi, lo  out  32 each  architectural HI/LO registers.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse; hi/lo already hold the new result in that cycle.
div_zero  out  1  one-cycle pulse on a DIV with divisor == 0.

Behaviour:
- Reset (rst low, async): state = IDLE, counter = 0, sel = MULT, hi = lo = 0, all pulses/done/div_zero = 0. Reset mid-operation drops the op silently, with no done and no stop pulse.
- States: IDLE, LAUNCH, WAIT, CAPTURE, ABORT. sel (registered) records the active unit.
- IDLE:
  - If start = 1, abort = 0, op = MULT → sel = MULT, go to LAUNCH.
  - If start = 1, abort = 0, op = DIV with divisor != 0 → sel = DIV, go to LAUNCH.
  - If start = 1, abort = 0, op = DIV with divisor == 0 → stay in IDLE; next cycle done = 1 and div_zero = 1; hi/lo unchanged.
  - Illegal op, or start with abort = 1 → ignored.
- LAUNCH (1 cycle): assert the sel unit's init (decoded from state, glitch-free from registers). On exit, counter = LAT(sel) - 1, go to WAIT.
- WAIT: decrement each cycle. When counter == 0, go to CAPTURE. WAIT lasts exactly LAT(sel) cycles.
- CAPTURE (1 cycle): at the exit edge, load hi/lo from the sel unit's outputs, go to IDLE, register done = 1.
- Latency: start accepted at edge E → done high, with new hi/lo, in the cycle after edge E + LAT + 2. With default MULT_LAT = 34, that is 36 edges after acceptance.
- abort = 1 in LAUNCH/WAIT/CAPTURE → go to ABORT. ABORT lasts 1 cycle and asserts the sel unit's stop, then returns to IDLE. No done; hi/lo unchanged.
- abort takes priority over a same-cycle capture. abort in IDLE is a no-op.
- start while busy is ignored and not queued.
- init and stop are never asserted together. At most one unit is driven per cycle. The non-selected unit's pulses stay 0.
- done and div_zero are cleared in every cycle in which they are not explicitly set.

Test Plan:
- Reset then idle: rst low → hi = lo = 0, busy = 0, all pulses 0. Release rst, hold start = 0 for 10 cycles → all outputs stay constant.
- MULT: start, op = 00, with mult model returning hi = 0x00000001, lo = 0x00000002 → mult_init high for exactly 1 cycle, 1 edge after acceptance. busy high 36 cycles. done pulses once, with hi = 0x1, lo = 0x2. div_init never asserts.
- DIV: start, op = 01, divisor = 7, div model returning hi = 0x3, lo = 0x5 → div_init pulse, done at E + 36, hi = 3, lo = 5.
- Divide by zero: start, op = 01, divisor = 0, with hi/lo preloaded to 0xAAAA/0x5555 → busy stays 0, no div_init, done = div_zero = 1 for 1 cycle, hi/lo unchanged.
- Abort: MULT started, abort = 1 at WAIT cycle 10 → mult_stop 1 cycle, then IDLE, no done, hi/lo unchanged. A second start during WAIT is ignored, with no extra init.
- Async reset mid-op: rst low at WAIT cycle 20, asynchronously between edges → busy = 0 immediately and hi = lo = 0. After release, a new MULT completes normally at E + 36.
